core_arbiter_rr: RTL and testbench
==================================

CORE_ARBITER_RR -- requirements
Module: core_arbiter_rr

Interface
REQ-001 SHALL have parameter N, default 2: number of requester ports, 2..8.
REQ-002 SHALL have parameter ADDR_W, default 30: word-address width, same as ptr.
REQ-003 SHALL have parameter DATA_W, default 32: data width, multiple of 8; BE_W = DATA_W/8.
REQ-004 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port req_start, input, N: per-port one-cycle request pulse.
REQ-008 SHALL have port req_write, input, N: per-port write (1) or read (0).
REQ-009 SHALL have port req_addr, input, N x ADDR_W: per-port word address.
REQ-010 SHALL have port req_data_wr, input, N x DATA_W: per-port write data.
REQ-011 SHALL have port req_data_be, input, N x BE_W: per-port byte enables.
REQ-012 SHALL have port req_ready, output, N: per-port one-cycle completion pulse.
REQ-013 SHALL have port req_data_rd, output, DATA_W: read data, shared by all ports.
REQ-014 SHALL have port req_overrun, output, N: sticky protocol-violation flags.
REQ-015 SHALL have ports bus_addr (output, ADDR_W), bus_start (output, 1), bus_write (output, 1), bus_data_wr (output, DATA_W), bus_data_be (output, BE_W), bus_ready (input, 1) and bus_data_rd (input, DATA_W): the downstream bus.

Function
REQ-016 Each port SHALL hold one pending slot, with a valid bit plus captured write, addr, data and be; the slot is loaded on the edge where req_start=1 and the slot is free.
REQ-017 A req_start to a port whose slot is valid SHALL be dropped and SHALL set req_overrun for that port; the flag stays set until reset.
REQ-018 A slot is free on the edge where its own req_ready pulses, so a req_start in that same cycle SHALL be accepted.
REQ-019 The FSM SHALL have two states, IDLE and BUSY.
REQ-020 In IDLE with any slot valid, the arbiter SHALL pick a winner, register the winner's fields onto bus_*, assert bus_start for exactly one cycle (the first BUSY cycle) and go to BUSY.
REQ-021 With FIXED_PRIO=0, the winner SHALL be the first valid port at or after the priority pointer, searching upward with wrap N-1 -> 0.
REQ-022 With FIXED_PRIO=1, the winner SHALL be the lowest-index valid port.
REQ-023 In BUSY, bus_addr, bus_write, bus_data_wr and bus_data_be SHALL hold stable until completion; bus_start SHALL be 0 after the first cycle.
REQ-024 In BUSY with bus_ready=1, req_ready[grant] SHALL be 1 that same cycle and req_data_rd SHALL equal bus_data_rd combinationally.
REQ-025 On that same edge, the grant slot SHALL clear, the pointer SHALL become (grant+1) mod N, and the FSM SHALL re-arbitrate among the remaining valid slots (grant masked).
REQ-026 If any slot remains valid after that masking, the FSM SHALL stay in BUSY with a new bus_start next cycle (no idle bubble); otherwise it SHALL go to IDLE.
REQ-027 bus_ready in IDLE, or in the bus_start cycle, SHALL be honoured only in BUSY; bus_ready in IDLE SHALL be ignored.
REQ-028 req_ready bits SHALL be 0 except for the grant port; req_data_rd SHALL be 0 when no req_ready is high.
REQ-029 Latency SHALL be: req_start at cycle T on an idle arbiter gives bus_start at T+2 and req_ready in the bus_ready cycle.
REQ-030 Round-robin SHALL guarantee each valid port is granted within N grants.

Reset
REQ-031 rst SHALL asynchronously force IDLE and clear all slot valid bits.
REQ-032 rst SHALL set the pointer to 0 and clear req_overrun.
REQ-033 rst SHALL force bus_start=0, bus_write=0, bus_addr=0, bus_data_wr=0, bus_data_be=0, req_ready=0 and req_data_rd=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no req_ready; a bus_ready arriving after reset is ignored.

Verification
REQ-035 Single read: N=2; port1 start at T, addr=0x100; bus_ready at T+4 with data 0xDEADBEEF -> bus_start=1 only at T+2 with bus_addr=0x100, bus_write=0; req_ready=2'b10 and req_data_rd=0xDEADBEEF at T+4.
REQ-036 Contention: ports 0 and 1 start together, pointer=0, ready 1 cycle after each bus_start -> port0 granted first, then port1's bus_start the cycle after port0's ready; pointer ends at 0.
REQ-037 Fairness: N=4, all ports re-request immediately after their own ready, for 16 grants -> grant order 0,1,2,3 repeating; each port gets 4 grants.
REQ-038 FIXED_PRIO=1: port0 re-requests continuously while port2 is pending -> port2 is never granted while port0 is valid.
REQ-039 Overrun: port0 pending, second start before its ready -> req_overrun[0]=1, only one bus transaction issued, and the original addr is kept.
REQ-040 Reset mid-BUSY: rst pulsed after bus_start, then bus_ready -> all outputs 0, no req_ready, FSM in IDLE.

Source files
------------

// File: rtl/core_arbiter_rr.sv
// Multi-port request arbiter: one pending slot per port, round-robin or
// fixed-priority selection, and a single downstream bus transaction at a time.
//
// state | meaning
// IDLE  | no transaction on the bus; waiting for any slot to become valid
// BUSY  | a granted transaction is on bus_*; waiting for bus_ready
module core_arbiter_rr #(
    parameter int N          = 2,
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    localparam int BE_W      = DATA_W / 8,
    localparam int PTR_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_start,
    input  logic [N-1:0]          req_write,
    input  logic [N*ADDR_W-1:0]   req_addr,
    input  logic [N*DATA_W-1:0]   req_data_wr,
    input  logic [N*BE_W-1:0]     req_data_be,
    output logic [N-1:0]          req_ready,
    output logic [DATA_W-1:0]     req_data_rd,
    output logic [N-1:0]          req_overrun,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic                  bus_start,
    output logic                  bus_write,
    output logic [DATA_W-1:0]     bus_data_wr,
    output logic [BE_W-1:0]       bus_data_be,
    input  logic                  bus_ready,
    input  logic [DATA_W-1:0]     bus_data_rd
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic [N-1:0]          vld_q, vld_d;
    logic [N-1:0]          ovr_q, ovr_d;
    logic [N-1:0]          wr_q, wr_d;
    logic [N*ADDR_W-1:0]   addr_q, addr_d;
    logic [N*DATA_W-1:0]   data_q, data_d;
    logic [N*BE_W-1:0]     be_q, be_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      grant_q, grant_d;
    logic                  bus_start_q, bus_start_d;
    logic                  bus_write_q, bus_write_d;
    logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]     bus_data_wr_q, bus_data_wr_d;
    logic [BE_W-1:0]       bus_data_be_q, bus_data_be_d;

    logic                  done;
    logic [N-1:0]          gnt_oh;
    logic [N-1:0]          cand;
    logic [PTR_W-1:0]      next_ptr;
    logic [PTR_W-1:0]      arb_base;
    logic                  win_found;
    logic [PTR_W-1:0]      win_idx;
    logic                  launch;
    int                    cand_idx;

    // Completion of the granted transaction; the freed slot drops out of
    // the candidate set so a back-to-back grant goes to someone else.
    always_comb begin
        done     = (state_q == BUSY) && bus_ready;
        gnt_oh   = done ? (N'(1) << grant_q) : '0;
        cand     = vld_q & ~gnt_oh;
        next_ptr = (int'(grant_q) == N - 1) ? '0 : grant_q + PTR_W'(1);
        arb_base = done ? next_ptr : ptr_q;
    end

    // Winner search: upward from the pointer with wrap, or lowest index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = 0;
        for (int k = 0; k < N; k++) begin
            if (FIXED_PRIO != 0) cand_idx = k;
            else                 cand_idx = (int'(arb_base) + k) % N;
            if (!win_found && cand[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand_idx);
            end
        end
        launch = win_found && ((state_q == IDLE) || done);
    end

    // Slot capture and overrun detection; a slot freed this edge may reload.
    always_comb begin
        vld_d  = vld_q;
        ovr_d  = ovr_q;
        wr_d   = wr_q;
        addr_d = addr_q;
        data_d = data_q;
        be_d   = be_q;
        for (int i = 0; i < N; i++) begin
            if (req_start[i]) begin
                if (vld_q[i] && !gnt_oh[i]) begin
                    ovr_d[i] = 1'b1;
                end else begin
                    vld_d[i]                       = 1'b1;
                    wr_d[i]                        = req_write[i];
                    addr_d[i*ADDR_W +: ADDR_W]     = req_addr[i*ADDR_W +: ADDR_W];
                    data_d[i*DATA_W +: DATA_W]     = req_data_wr[i*DATA_W +: DATA_W];
                    be_d[i*BE_W +: BE_W]           = req_data_be[i*BE_W +: BE_W];
                end
            end else if (gnt_oh[i]) begin
                vld_d[i] = 1'b0;
            end
        end
    end

    // FSM next state and bus launch; bus fields hold between launches.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        bus_start_d   = launch;
        bus_write_d   = bus_write_q;
        bus_addr_d    = bus_addr_q;
        bus_data_wr_d = bus_data_wr_q;
        bus_data_be_d = bus_data_be_q;
        if (done) begin
            ptr_d   = next_ptr;
            state_d = IDLE;
        end
        if (launch) begin
            state_d       = BUSY;
            grant_d       = win_idx;
            bus_write_d   = wr_q[win_idx];
            bus_addr_d    = addr_q[int'(win_idx)*ADDR_W +: ADDR_W];
            bus_data_wr_d = data_q[int'(win_idx)*DATA_W +: DATA_W];
            bus_data_be_d = be_q[int'(win_idx)*BE_W +: BE_W];
        end
    end

    // State, slot and bus registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            vld_q         <= '0;
            ovr_q         <= '0;
            wr_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            be_q          <= '0;
            ptr_q         <= '0;
            grant_q       <= '0;
            bus_start_q   <= 1'b0;
            bus_write_q   <= 1'b0;
            bus_addr_q    <= '0;
            bus_data_wr_q <= '0;
            bus_data_be_q <= '0;
        end else begin
            state_q       <= state_d;
            vld_q         <= vld_d;
            ovr_q         <= ovr_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            be_q          <= be_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            bus_start_q   <= bus_start_d;
            bus_write_q   <= bus_write_d;
            bus_addr_q    <= bus_addr_d;
            bus_data_wr_q <= bus_data_wr_d;
            bus_data_be_q <= bus_data_be_d;
        end
    end

    // Completion is reported combinationally in the bus_ready cycle.
    always_comb begin
        req_ready   = gnt_oh;
        req_data_rd = done ? bus_data_rd : '0;
        req_overrun = ovr_q;
        bus_start   = bus_start_q;
        bus_write   = bus_write_q;
        bus_addr    = bus_addr_q;
        bus_data_wr = bus_data_wr_q;
        bus_data_be = bus_data_be_q;
    end

endmodule

// File: tb/tb_core_arbiter_rr.sv
// Bench for core_arbiter_rr: a round-robin and a fixed-priority instance
// share request stimulus; each is compared every cycle to a transaction-level
// reference model, plus directed scenarios for latency, contention, overrun,
// reset and fairness.
module tb_core_arbiter_rr;
    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_start, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data_wr;
    logic [N*BW-1:0] req_data_be;
    logic            bus_ready   [2];
    logic [DW-1:0]   bus_data_rd [2];

    logic [N-1:0]    o_ready [2];
    logic [N-1:0]    o_ovr   [2];
    logic [DW-1:0]   o_rd    [2];
    logic [AW-1:0]   o_addr  [2];
    logic            o_start [2];
    logic            o_write [2];
    logic [DW-1:0]   o_wdata [2];
    logic [BW-1:0]   o_be    [2];

    core_arbiter_rr #(.N(N), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst), .req_start(req_start), .req_write(req_write),
        .req_addr(req_addr), .req_data_wr(req_data_wr), .req_data_be(req_data_be),
        .req_ready(o_ready[0]), .req_data_rd(o_rd[0]), .req_overrun(o_ovr[0]),
        .bus_addr(o_addr[0]), .bus_start(o_start[0]), .bus_write(o_write[0]),
        .bus_data_wr(o_wdata[0]), .bus_data_be(o_be[0]),
        .bus_ready(bus_ready[0]), .bus_data_rd(bus_data_rd[0]));

    core_arbiter_rr #(.N(N), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst), .req_start(req_start), .req_write(req_write),
        .req_addr(req_addr), .req_data_wr(req_data_wr), .req_data_be(req_data_be),
        .req_ready(o_ready[1]), .req_data_rd(o_rd[1]), .req_overrun(o_ovr[1]),
        .bus_addr(o_addr[1]), .bus_start(o_start[1]), .bus_write(o_write[1]),
        .bus_data_wr(o_wdata[1]), .bus_data_be(o_be[1]),
        .bus_ready(bus_ready[1]), .bus_data_rd(bus_data_rd[1]));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: pending slots, the transaction on the bus, the pointer.
    logic [N-1:0]  m_vld  [2];
    logic [N-1:0]  m_ovr  [2];
    logic          m_wr   [2][N];
    logic [AW-1:0] m_addr [2][N];
    logic [DW-1:0] m_data [2][N];
    logic [BW-1:0] m_be   [2][N];
    bit            m_busy [2];
    bit            m_first[2];
    int            m_cur  [2];
    int            m_ptr  [2];
    logic          m_bwr  [2];
    logic [AW-1:0] m_baddr[2];
    logic [DW-1:0] m_bdata[2];
    logic [BW-1:0] m_bbe  [2];

    logic [N-1:0]  s_ready[2];
    logic          s_start[2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_rd   [2];
    logic [N-1:0]  s_ovr  [2];

    function automatic void model_reset(int k);
        m_vld[k] = '0; m_ovr[k] = '0;
        m_busy[k] = 0; m_first[k] = 0; m_cur[k] = 0; m_ptr[k] = 0;
        m_bwr[k] = 0; m_baddr[k] = '0; m_bdata[k] = '0; m_bbe[k] = '0;
    endfunction

    function automatic int pick(int k, logic [N-1:0] c, int base);
        for (int off = 0; off < N; off++) begin
            int i = (k == 1) ? off : (base + off) % N;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_step(int k);
        logic [N-1:0] c = m_vld[k];
        bit done = m_busy[k] && bus_ready[k];
        int w;
        if (done) begin
            m_vld[k][m_cur[k]] = 1'b0;
            c[m_cur[k]] = 1'b0;
            m_ptr[k] = (m_cur[k] + 1) % N;
        end
        for (int p = 0; p < N; p++) begin
            if (req_start[p]) begin
                if (m_vld[k][p]) m_ovr[k][p] = 1'b1;
                else begin
                    m_vld[k][p]  = 1'b1;
                    m_wr[k][p]   = req_write[p];
                    m_addr[k][p] = req_addr[p*AW +: AW];
                    m_data[k][p] = req_data_wr[p*DW +: DW];
                    m_be[k][p]   = req_data_be[p*BW +: BW];
                end
            end
        end
        if (!m_busy[k] || done) begin
            w = pick(k, c, m_ptr[k]);
            if (w >= 0) begin
                m_busy[k] = 1; m_first[k] = 1; m_cur[k] = w;
                m_bwr[k] = m_wr[k][w]; m_baddr[k] = m_addr[k][w];
                m_bdata[k] = m_data[k][w]; m_bbe[k] = m_be[k][w];
            end else begin
                m_busy[k] = 0; m_first[k] = 0;
            end
        end else begin
            m_first[k] = 0;
        end
    endfunction

    task automatic model_check(int k);
        bit done = m_busy[k] && bus_ready[k];
        logic [N-1:0]  er = done ? (N'(1) << m_cur[k]) : '0;
        logic [DW-1:0] ed = done ? bus_data_rd[k] : '0;
        chk($sformatf("req_ready%0d", k), 64'(o_ready[k]), 64'(er));
        chk($sformatf("req_data_rd%0d", k), 64'(o_rd[k]), 64'(ed));
        chk($sformatf("req_overrun%0d", k), 64'(o_ovr[k]), 64'(m_ovr[k]));
        chk($sformatf("bus_start%0d", k), 64'(o_start[k]), 64'(m_busy[k] && m_first[k]));
        chk($sformatf("bus_addr%0d", k), 64'(o_addr[k]), 64'(m_baddr[k]));
        chk($sformatf("bus_write%0d", k), 64'(o_write[k]), 64'(m_bwr[k]));
        chk($sformatf("bus_data_wr%0d", k), 64'(o_wdata[k]), 64'(m_bdata[k]));
        chk($sformatf("bus_data_be%0d", k), 64'(o_be[k]), 64'(m_bbe[k]));
        s_ready[k] = o_ready[k]; s_start[k] = o_start[k];
        s_addr[k] = o_addr[k]; s_rd[k] = o_rd[k]; s_ovr[k] = o_ovr[k];
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic run_cycle();
        #3;
        model_check(0);
        model_check(1);
        @(posedge clk);
        if (!rst) begin
            model_step(0);
            model_step(1);
        end
        #1;
    endtask

    task automatic clear_inputs();
        req_start = '0; req_write = '0; req_addr = '0; req_data_wr = '0; req_data_be = '0;
        for (int k = 0; k < 2; k++) begin
            bus_ready[k] = 1'b0; bus_data_rd[k] = '0;
        end
    endtask

    task automatic set_rdy(input logic r, input logic [DW-1:0] d);
        for (int k = 0; k < 2; k++) begin
            bus_ready[k] = r; bus_data_rd[k] = d;
        end
    endtask

    task automatic start_port(input int p, input logic w, input logic [AW-1:0] a);
        req_start[p] = 1'b1;
        req_write[p] = w;
        req_addr[p*AW +: AW] = a;
        req_data_wr[p*DW +: DW] = $urandom;
        req_data_be[p*BW +: BW] = BW'($urandom);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        run_cycle();
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        clear_inputs();
        for (int p = 0; p < N; p++)
            if ($urandom_range(0, 3) == 0) start_port(p, 1'($urandom), AW'($urandom));
        for (int k = 0; k < 2; k++) begin
            bus_ready[k] = 1'($urandom);
            bus_data_rd[k] = $urandom;
        end
    endtask

    int grants[$];
    int fp_cnt[N];
    int nstart;

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        @(posedge clk); #1;
        run_cycle();
        chk("reset_start", 64'(s_start[0]), 64'd0);
        rst = 1'b0;

        // Single read on port 1: bus_start at T+2, completion at T+4.
        clear_inputs(); start_port(1, 1'b0, AW'('h100));
        run_cycle();
        clear_inputs(); run_cycle();
        run_cycle();
        chk("rd1_start", 64'(s_start[0]), 64'd1);
        chk("rd1_addr", 64'(s_addr[0]), 64'h100);
        run_cycle();
        chk("rd1_hold", 64'(s_start[0]), 64'd0);
        set_rdy(1'b1, 32'hDEADBEEF);
        run_cycle();
        chk("rd1_ready", 64'(s_ready[0]), 64'b0010);
        chk("rd1_data", 64'(s_rd[0]), 64'hDEADBEEF);
        clear_inputs(); run_cycle();

        // Contention between ports 0 and 1 from a reset pointer.
        do_reset();
        start_port(0, 1'b1, AW'('h10)); start_port(1, 1'b0, AW'('h20));
        run_cycle();
        clear_inputs(); run_cycle(); run_cycle();
        set_rdy(1'b1, 32'h1111); run_cycle();
        chk("cont_first", 64'(s_ready[0]), 64'b0001);
        set_rdy(1'b0, '0); run_cycle();
        chk("cont_restart", 64'(s_start[0]), 64'd1);
        chk("cont_addr1", 64'(s_addr[0]), 64'h20);
        set_rdy(1'b1, 32'h2222); run_cycle();
        chk("cont_second", 64'(s_ready[0]), 64'b0010);
        clear_inputs();
        start_port(0, 1'b0, AW'('h30)); start_port(1, 1'b0, AW'('h40));
        run_cycle();
        clear_inputs(); run_cycle(); run_cycle();
        set_rdy(1'b1, 32'h3333); run_cycle();
        chk("ptr_wrap", 64'(s_ready[0]), 64'b0001);
        run_cycle(); run_cycle();
        clear_inputs(); run_cycle();

        // Overrun: second start on port 0 while pending is dropped.
        do_reset();
        start_port(0, 1'b1, AW'('hAAA)); run_cycle();
        clear_inputs(); start_port(0, 1'b1, AW'('hBBB)); run_cycle();
        clear_inputs(); run_cycle();
        chk("ovr_addr", 64'(s_addr[0]), 64'hAAA);
        chk("ovr_flag", 64'(s_ovr[0][0]), 64'd1);
        set_rdy(1'b1, '0);
        nstart = 0;
        for (int c = 0; c < 6; c++) begin
            run_cycle();
            nstart += int'(s_start[0]);
        end
        chk("ovr_one_txn", 64'(nstart), 64'd0);
        chk("ovr_sticky", 64'(s_ovr[0][0]), 64'd1);

        // Reset while BUSY: transaction abandoned, late bus_ready ignored.
        do_reset();
        start_port(2, 1'b1, AW'('h55)); run_cycle();
        clear_inputs(); run_cycle(); run_cycle();
        chk("rstb_start", 64'(s_start[0]), 64'd1);
        rst = 1'b1; model_reset(0); model_reset(1);
        run_cycle();
        chk("rstb_addr", 64'(s_addr[0]), 64'd0);
        rst = 1'b0;
        set_rdy(1'b1, 32'hFFFF_FFFF); run_cycle();
        chk("rstb_noready", 64'(s_ready[0]), 64'd0);
        chk("rstb_nodata", 64'(s_rd[0]), 64'd0);
        clear_inputs(); run_cycle();

        // Fairness: every port requests continuously.
        do_reset();
        for (int p = 0; p < N; p++) fp_cnt[p] = 0;
        for (int c = 0; c < 40; c++) begin
            clear_inputs();
            for (int p = 0; p < N; p++) start_port(p, 1'b0, AW'($urandom));
            set_rdy(1'b1, $urandom);
            run_cycle();
            for (int p = 0; p < N; p++) begin
                if (s_ready[0][p]) grants.push_back(p);
                if (s_ready[1][p]) fp_cnt[p]++;
            end
        end
        chk("rr_ngrants", 64'(grants.size() >= 16), 64'd1);
        for (int g = 0; g < 16 && g < grants.size(); g++)
            chk($sformatf("rr_order%0d", g), 64'(grants[g]), 64'(g % N));
        chk("fp_port2_starved", 64'(fp_cnt[2]), 64'd0);
        chk("fp_port0_served", 64'(fp_cnt[0] > 0), 64'd1);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else begin
                randomize_inputs();
                run_cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
